verificador_xor: RTL and testbench

Self-checking response stage that sits directly downstream of the XOR gate under test in the lab bench. It watches each 2-bit stimulus vector applied to the gate and the gate's 1-bit output. It computes the expected XOR, aligns it to the gate's latency, and counts mismatches. After a fixed number of vectors it reports a pass/fail verdict, so lab runs no longer need manual VCD inspection.

---
 rtl/verificador_xor_pkg.sv | 20 ++
 rtl/verificador_xor_linea_retardo.sv | 42 ++++
 rtl/verificador_xor.sv | 111 +++++++++++
 tb/tb_verificador_xor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/verificador_xor_pkg.sv
// Shared definitions for the verificador_xor response checker: run states,
// the truth table of the gate under test and the alignment depth bound.
package verificador_xor_pkg;

   typedef enum logic [1:0] {
      REPOSO    = 2'd0,
      CORRIENDO = 2'd1,
      FIN       = 2'd2
   } estado_t;

   // Truth table of the gate under test, indexed by the 2-bit stimulus (XOR).
   localparam logic [3:0] TABLA_ESPERADA = 4'b0110;

   localparam int LATENCIA_MAX = 7;

   function automatic logic valor_esperado(input logic [1:0] estimulo);
      return TABLA_ESPERADA[estimulo];
   endfunction

endpackage

// File: rtl/verificador_xor_linea_retardo.sv
// Valid+data shift register of configurable depth with synchronous clear;
// depth 0 degenerates to a direct wire.
module linea_retardo #(
   parameter int PROFUNDIDAD = 0,
   parameter int ANCHO       = 3
) (
   input  logic             reloj,
   input  logic             limpiar,
   input  logic             push_valid,
   input  logic [ANCHO-1:0] push_data,
   output logic             pop_valid,
   output logic [ANCHO-1:0] pop_data
);

   if (PROFUNDIDAD == 0) begin : g_directo
      assign pop_valid = push_valid;
      assign pop_data  = push_data;
   end else begin : g_registros
      logic [PROFUNDIDAD-1:0] valid_sr;
      logic [ANCHO-1:0]       data_sr [PROFUNDIDAD];

      // Only the valid bits need clearing; stale data is never consumed.
      always_ff @(posedge reloj) begin
         if (limpiar) begin
            valid_sr <= '0;
         end else begin
            valid_sr[0] <= push_valid;
            for (int i = 1; i < PROFUNDIDAD; i++) begin
               valid_sr[i] <= valid_sr[i-1];
            end
         end
         data_sr[0] <= push_data;
         for (int i = 1; i < PROFUNDIDAD; i++) begin
            data_sr[i] <= data_sr[i-1];
         end
      end

      assign pop_valid = valid_sr[PROFUNDIDAD-1];
      assign pop_data  = data_sr[PROFUNDIDAD-1];
   end

endmodule

// File: rtl/verificador_xor.sv
// Self-checking response stage for an XOR gate: aligns expected values to the
// gate latency, counts mismatches and reports a verdict. Optional coverage
// tracking is enabled with the macro VERIFICADOR_XOR_COBERTURA_EN.
module verificador_xor
   import verificador_xor_pkg::*;
#(
   parameter int NUM_VECTORES = 4,
   parameter int LATENCIA_DUT = 0,
   parameter int ANCHO_CONT   = 8
) (
   input  logic                  Reloj,
   input  logic                  Reinicio,
   input  logic                  Inicio,
   input  logic                  VectorValido,
   input  logic [1:0]            Estimulo,
   input  logic                  SalidaDut,
   output logic                  Ocupado,
   output logic                  Terminado,
   output logic                  Aprobado,
   output logic [ANCHO_CONT-1:0] Errores,
   output logic [ANCHO_CONT-1:0] Revisados,
   output logic [1:0]            PrimerFallo,
   output logic [3:0]            Cobertura
);

   localparam int PROFUNDIDAD = (LATENCIA_DUT > LATENCIA_MAX) ? LATENCIA_MAX : LATENCIA_DUT;
   localparam logic [ANCHO_CONT-1:0] NUM_C = ANCHO_CONT'(NUM_VECTORES);
   localparam logic [ANCHO_CONT-1:0] UNO   = ANCHO_CONT'(1);

   estado_t               estado, estado_sig;
   logic [ANCHO_CONT-1:0] aceptados, revisados, errores;
   logic [1:0]            primer_fallo;
   logic                  limpiar, acepta, compara, falla, cobertura_ok;
   logic                  pop_valid;
   logic [2:0]            pop_data;

   // Inicio restarts the run: it blocks acceptance and discards in-flight results.
   assign limpiar = Reinicio | Inicio;
   assign acepta  = VectorValido && (estado == CORRIENDO) && !Inicio && (aceptados < NUM_C);
   assign compara = pop_valid && (estado == CORRIENDO) && !Inicio;
   assign falla   = compara && (pop_data[2] != SalidaDut);

   linea_retardo #(
      .PROFUNDIDAD (PROFUNDIDAD),
      .ANCHO       (3)
   ) u_linea_retardo (
      .reloj      (Reloj),
      .limpiar    (limpiar),
      .push_valid (acepta),
      .push_data  ({valor_esperado(Estimulo), Estimulo}),
      .pop_valid  (pop_valid),
      .pop_data   (pop_data)
   );

   always_ff @(posedge Reloj) begin
      if (Reinicio) estado <= REPOSO;
      else          estado <= estado_sig;
   end

   always_comb begin
      estado_sig = estado;
      case (estado)
         REPOSO:    if (Inicio) estado_sig = CORRIENDO;
         CORRIENDO: begin
            if (Inicio)                  estado_sig = CORRIENDO;
            else if (revisados == NUM_C) estado_sig = FIN;
         end
         FIN:       if (Inicio) estado_sig = CORRIENDO;
         default:   estado_sig = REPOSO;
      endcase
   end

   always_ff @(posedge Reloj) begin
      if (limpiar) begin
         aceptados    <= '0;
         revisados    <= '0;
         errores      <= '0;
         primer_fallo <= 2'b00;
      end else begin
         if (acepta)  aceptados <= aceptados + UNO;
         if (compara) revisados <= revisados + UNO;
         if (falla) begin
            if (errores != '1) errores <= errores + UNO;
            if (errores == '0) primer_fallo <= pop_data[1:0];
         end
      end
   end

`ifdef VERIFICADOR_XOR_COBERTURA_EN
   logic [3:0] cobertura_q;

   always_ff @(posedge Reloj) begin
      if (limpiar)      cobertura_q <= 4'b0000;
      else if (compara) cobertura_q[pop_data[1:0]] <= 1'b1;
   end

   assign Cobertura    = cobertura_q;
   assign cobertura_ok = (cobertura_q == 4'b1111);
`else
   assign Cobertura    = 4'b0000;
   assign cobertura_ok = 1'b1;
`endif

   assign Ocupado     = (estado == CORRIENDO);
   assign Terminado   = (estado == FIN);
   assign Aprobado    = Terminado && (errores == '0) && cobertura_ok;
   assign Errores     = errores;
   assign Revisados   = revisados;
   assign PrimerFallo = primer_fallo;

endmodule

// File: tb/tb_verificador_xor.sv
// Directed bench for verificador_xor: one zero-latency checker and one
// two-cycle-latency checker fed by a modelled gate with selectable delay.
module tb_verificador_xor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

`ifdef VERIFICADOR_XOR_COBERTURA_EN
   localparam logic [7:0] COB_FULL = 8'h0F;
`else
   localparam logic [7:0] COB_FULL = 8'h00;
`endif

   logic       rst;
   logic       ini0, vv0, sal0;
   logic [1:0] est0;
   logic       ocu0, ter0, apr0;
   logic [7:0] err0, rev0;
   logic [1:0] pf0;
   logic [3:0] cob0;

   logic       ini2, vv2, sal2;
   logic [1:0] est2;
   logic       ocu2, ter2, apr2;
   logic [7:0] err2, rev2;
   logic [1:0] pf2;
   logic [3:0] cob2;

   int checks = 0;
   int errors = 0;

   verificador_xor #(.NUM_VECTORES(4), .LATENCIA_DUT(0), .ANCHO_CONT(8)) dut0 (
      .Reloj(clk), .Reinicio(rst), .Inicio(ini0), .VectorValido(vv0),
      .Estimulo(est0), .SalidaDut(sal0), .Ocupado(ocu0), .Terminado(ter0),
      .Aprobado(apr0), .Errores(err0), .Revisados(rev0),
      .PrimerFallo(pf0), .Cobertura(cob0)
   );

   verificador_xor #(.NUM_VECTORES(4), .LATENCIA_DUT(2), .ANCHO_CONT(8)) dut2 (
      .Reloj(clk), .Reinicio(rst), .Inicio(ini2), .VectorValido(vv2),
      .Estimulo(est2), .SalidaDut(sal2), .Ocupado(ocu2), .Terminado(ter2),
      .Aprobado(apr2), .Errores(err2), .Revisados(rev2),
      .PrimerFallo(pf2), .Cobertura(cob2)
   );

   // Gate model for dut2: XOR output delayed by 1 or 2 cycles.
   int   retardo = 2;
   logic d1 = 1'b0, d2 = 1'b0;
   always @(posedge clk) begin
      d1 <= est2[1] ^ est2[0];
      d2 <= d1;
   end
   assign sal2 = (retardo == 2) ? d2 : d1;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start0();
      ini0 = 1'b1; tick(); ini0 = 1'b0;
   endtask

   task automatic start2();
      ini2 = 1'b1; tick(); ini2 = 1'b0;
   endtask

   task automatic vec0(input logic [1:0] s, input logic o);
      vv0 = 1'b1; est0 = s; sal0 = o;
      tick();
      vv0 = 1'b0;
   endtask

   task automatic vec2(input logic [1:0] s);
      vv2 = 1'b1; est2 = s;
      tick();
      vv2 = 1'b0;
   endtask

   task automatic chk_reset0(input string tag);
      chk({tag, "_ocupado"},   {7'd0, ocu0}, 8'h00);
      chk({tag, "_terminado"}, {7'd0, ter0}, 8'h00);
      chk({tag, "_aprobado"},  {7'd0, apr0}, 8'h00);
      chk({tag, "_errores"},   err0,         8'h00);
      chk({tag, "_revisados"}, rev0,         8'h00);
      chk({tag, "_primer"},    {6'd0, pf0},  8'h00);
      chk({tag, "_cobertura"}, {4'd0, cob0}, 8'h00);
   endtask

   initial begin
      rst = 1'b1;
      ini0 = 1'b0; vv0 = 1'b0; est0 = 2'b00; sal0 = 1'b0;
      ini2 = 1'b0; vv2 = 1'b0; est2 = 2'b00;
      tick(); tick();
      chk_reset0("reset");
      chk("reset_terminado2", {7'd0, ter2}, 8'h00);
      rst = 1'b0;
      tick();

      // Correct gate, zero latency
      start0();
      chk("t1_ocupado_tras_inicio", {7'd0, ocu0}, 8'h01);
      vec0(2'b00, 1'b0); vec0(2'b01, 1'b1); vec0(2'b10, 1'b1); vec0(2'b11, 1'b0);
      chk("t1_revisados_4", rev0, 8'd4);
      chk("t1_terminado_aun_no", {7'd0, ter0}, 8'h00);
      tick();
      chk("t1_terminado", {7'd0, ter0}, 8'h01);
      chk("t1_ocupado_cae", {7'd0, ocu0}, 8'h00);
      chk("t1_errores", err0, 8'd0);
      chk("t1_aprobado", {7'd0, apr0}, 8'h01);
      chk("t1_cobertura", {4'd0, cob0}, COB_FULL);

      // Stuck-at-0 gate
      start0();
      chk("t2_revisados_limpio", rev0, 8'd0);
      chk("t2_terminado_limpio", {7'd0, ter0}, 8'h00);
      vec0(2'b00, 1'b0); vec0(2'b01, 1'b0); vec0(2'b10, 1'b0); vec0(2'b11, 1'b0);
      tick();
      chk("t2_errores", err0, 8'd2);
      chk("t2_primer_fallo", {6'd0, pf0}, 8'h01);
      chk("t2_terminado", {7'd0, ter0}, 8'h01);
      chk("t2_aprobado", {7'd0, apr0}, 8'h00);

      // Six pulses, only four counted; the extra two would mismatch
      start0();
      vec0(2'b00, 1'b0); vec0(2'b01, 1'b1); vec0(2'b10, 1'b1); vec0(2'b11, 1'b0);
      chk("t3_revisados_4", rev0, 8'd4);
      chk("t3_terminado_aun_no", {7'd0, ter0}, 8'h00);
      vec0(2'b01, 1'b0);
      chk("t3_terminado", {7'd0, ter0}, 8'h01);
      vec0(2'b10, 1'b0);
      chk("t3_revisados_final", rev0, 8'd4);
      chk("t3_errores", err0, 8'd0);
      chk("t3_aprobado", {7'd0, apr0}, 8'h01);

      // Restart mid-run, with a bad vector coinciding with Inicio
      start0();
      vec0(2'b01, 1'b0); vec0(2'b10, 1'b1);
      chk("t4_revisados_2", rev0, 8'd2);
      chk("t4_errores_1", err0, 8'd1);
      ini0 = 1'b1; vv0 = 1'b1; est0 = 2'b11; sal0 = 1'b1;
      tick();
      ini0 = 1'b0; vv0 = 1'b0;
      chk("t4_revisados_0", rev0, 8'd0);
      chk("t4_errores_0", err0, 8'd0);
      chk("t4_ocupado", {7'd0, ocu0}, 8'h01);
      chk("t4_primer_fallo", {6'd0, pf0}, 8'h00);
      chk("t4_cobertura_0", {4'd0, cob0}, 8'h00);
      vec0(2'b00, 1'b0); vec0(2'b01, 1'b1); vec0(2'b10, 1'b1); vec0(2'b11, 1'b0);
      tick();
      chk("t4_terminado", {7'd0, ter0}, 8'h01);
      chk("t4_revisados_4", rev0, 8'd4);
      chk("t4_errores_fin", err0, 8'd0);
      chk("t4_aprobado", {7'd0, apr0}, 8'h01);

      // Reset mid-run, then pulses in REPOSO are ignored
      start0();
      vec0(2'b01, 1'b0); vec0(2'b10, 1'b1);
      chk("t5_errores_previo", err0, 8'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset0("t5");
      vec0(2'b01, 1'b0); vec0(2'b10, 1'b0);
      chk("t5_revisados_reposo", rev0, 8'd0);
      chk("t5_errores_reposo", err0, 8'd0);
      chk("t5_ocupado_reposo", {7'd0, ocu0}, 8'h00);

      // Two-cycle latency checker, gate delayed 2 cycles
      retardo = 2;
      start2();
      vec2(2'b00); vec2(2'b01); vec2(2'b10); vec2(2'b11);
      est2 = 2'b00;
      tick(); tick();
      chk("t6_revisados", rev2, 8'd4);
      chk("t6_terminado_aun_no", {7'd0, ter2}, 8'h00);
      tick();
      chk("t6_terminado", {7'd0, ter2}, 8'h01);
      chk("t6_errores", err2, 8'd0);
      chk("t6_aprobado", {7'd0, apr2}, 8'h01);

      // Same checker, gate delayed only 1 cycle
      retardo = 1;
      start2();
      vec2(2'b00); vec2(2'b01); vec2(2'b10); vec2(2'b11);
      est2 = 2'b00;
      tick(); tick(); tick();
      chk("t7_terminado", {7'd0, ter2}, 8'h01);
      chk("t7_errores", err2, 8'd2);
      chk("t7_aprobado", {7'd0, apr2}, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
